// File: rtl/instload_pkg.sv
// -----------------------------------------------------------------------------
// instload_pkg
// Shared definitions for the boot-time program loader: the FSM state type,
// the word geometry (four bytes per instruction word) and the address step
// between consecutive instruction words.
// -----------------------------------------------------------------------------
package instload_pkg;

   // Loader FSM states.
   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } state_e;

   // Bytes packed into one instruction word.
   localparam int BYTES_PER_WORD = 4;

   // Byte-address increment between consecutive words.
   localparam int ADR_STEP = 4;

   // True when a two-bit byte index points at the final byte of a word.
   function automatic logic isLastIndex(input logic [1:0] idx);
      return idx == 2'(BYTES_PER_WORD - 1);
   endfunction

endpackage

// File: rtl/instload_packer.sv
// -----------------------------------------------------------------------------
// instload_packer
// Four-byte big-endian assembly register. The first accepted byte of a word
// lands in bits [31:24], the fourth in bits [7:0].
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   accept_i in   a byte is being consumed this cycle
//   clear_i  in   discard any partial word and restart at byte 0
//   byte_i   in   byte being consumed
//   word_o   out  assembled word, including byte_i at the current index
//   last_o   out  byte_i completes the word (index 3 and accept_i)
// -----------------------------------------------------------------------------
module instload_packer
   import instload_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        accept_i,
   input  logic        clear_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        last_o
);

   logic [1:0]  index_q;
   logic [31:0] word_q;
   logic [31:0] merged_d;

   // word_o merges the byte presented this cycle so the consumer can capture
   // the complete word on the same edge that accepts the fourth byte.
   always_comb begin
      merged_d = word_q;
      unique case (index_q)
         2'd0:    merged_d[31:24] = byte_i;
         2'd1:    merged_d[23:16] = byte_i;
         2'd2:    merged_d[15:8]  = byte_i;
         default: merged_d[7:0]   = byte_i;
      endcase
   end

   // Clear takes priority so a new load never inherits a stale partial word.
   // The two-bit index wraps to 0 naturally after the fourth byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index_q <= '0;
         word_q  <= '0;
      end else if (clear_i) begin
         index_q <= '0;
         word_q  <= '0;
      end else if (accept_i) begin
         index_q <= index_q + 2'd1;
         word_q  <= merged_d;
      end
   end

   assign word_o = merged_d;
   assign last_o = accept_i && isLastIndex(index_q);

endmodule

// File: rtl/instload.sv
// -----------------------------------------------------------------------------
// instload
// Boot-time program loader. Takes a byte stream over valid/ready, packs each
// four bytes big-endian into an instruction word and writes it to the
// instruction RAM at consecutive word-aligned addresses from a base address.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   start       in   begin a load (sampled in IDLE only)
//   base_adr    in   first byte address (low two bits ignored)
//   word_count  in   number of words to load (sampled with start)
//   in_valid    in   byte stream valid
//   in_data     in   byte stream data
//   in_ready    out  loader accepts a byte this cycle
//   we          out  instruction memory write enable, one cycle per word
//   adr         out  write byte address
//   writedata   out  write data
//   busy        out  load in progress
//   done        out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module instload
   import instload_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 17
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BUS_WIDTH-1:0]  base_adr,
   input  logic [BUS_WIDTH-3:0]  word_count,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  we,
   output logic [BUS_WIDTH-1:0]  adr,
   output logic [DATA_WIDTH-1:0] writedata,
   output logic                  busy,
   output logic                  done
);

   localparam logic [BUS_WIDTH-3:0] ONE_WORD = (BUS_WIDTH-2)'(1);
   localparam logic [BUS_WIDTH-1:0] ADR_INC  = BUS_WIDTH'(ADR_STEP);
   localparam logic [BUS_WIDTH-1:0] ALIGN    = ~BUS_WIDTH'(BYTES_PER_WORD - 1);

   state_e                  state_q;
   logic [BUS_WIDTH-1:0]    adr_q;
   logic [BUS_WIDTH-3:0]    remaining_q;
   logic [DATA_WIDTH-1:0]   writeData_q;
   logic                    we_q;
   logic                    inReady_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    byteAccept;
   logic                    packerClear;
   logic [31:0]             packedWord;
   logic                    lastByte;
   logic [BUS_WIDTH-1:0]    adrNext_d;
   logic [BUS_WIDTH-1:0]    alignedBase_d;

   // inReady_q is only ever set while entering COLLECT, so it doubles as the
   // COLLECT decode and keeps in_ready free of any path from in_valid.
   assign byteAccept = in_valid && inReady_q;

   // Restart byte assembly on every accepted start and after every write so
   // each word begins at byte index 0.
   assign packerClear = ((state_q == IDLE) && start) || (state_q == WRITE);

   // Address arithmetic wraps modulo 2^BUS_WIDTH by plain truncation.
   assign adrNext_d     = adr_q + ADR_INC;
   assign alignedBase_d = base_adr & ALIGN;

   instload_packer u_packer (
      .clk      (clk),
      .reset_n  (reset_n),
      .accept_i (byteAccept),
      .clear_i  (packerClear),
      .byte_i   (in_data),
      .word_o   (packedWord),
      .last_o   (lastByte)
   );

   // Loader FSM with all outputs registered. we and done default low each
   // cycle so they can only ever be one-cycle pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         adr_q       <= '0;
         remaining_q <= '0;
         writeData_q <= '0;
         we_q        <= 1'b0;
         inReady_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     adr_q       <= alignedBase_d;
                     remaining_q <= word_count;
                     inReady_q   <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= COLLECT;
                  end else begin
                     // An empty load completes immediately; adr keeps its
                     // previous value since no word is written.
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            COLLECT: begin
               if (lastByte) begin
                  writeData_q <= packedWord;
                  we_q        <= 1'b1;
                  inReady_q   <= 1'b0;
                  state_q     <= WRITE;
               end
            end
            WRITE: begin
               adr_q       <= adrNext_d;
               remaining_q <= remaining_q - ONE_WORD;
               if (remaining_q == ONE_WORD) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  inReady_q <= 1'b1;
                  state_q   <= COLLECT;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign we        = we_q;
   assign adr       = adr_q;
   assign writedata = writeData_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_instload.sv
// -----------------------------------------------------------------------------
// tb_instload
// Self-checking bench for the program loader. A high-level model turns each
// requested load (base, count, byte list) into the list of memory writes it
// must produce; a monitor compares every write strobe against that list.
// -----------------------------------------------------------------------------
module tb_instload;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [16:0] base_adr = '0;
   logic [14:0] word_count = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        we;
   logic [16:0] adr;
   logic [31:0] writedata;
   logic        busy;
   logic        done;

   instload #(.DATA_WIDTH(32), .BUS_WIDTH(17)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_adr   (base_adr),
      .word_count (word_count),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .we         (we),
      .adr        (adr),
      .writedata  (writedata),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] adr;
      logic [31:0] data;
   } wr_t;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  startCyc = 0;
   int  doneCount = 0;
   bit  prevWe = 1'b0;
   wr_t expQ[$];
   wr_t logQ[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Model: a load writes word w at the word-aligned base plus 4w, modulo the
   // 128 KiB address space, with bytes 4w..4w+3 in big-endian order.
   function automatic void modelLoad(input int base, input int count, input logic [7:0] bytes[$]);
      for (int w = 0; w < count; w++) begin
         wr_t e;
         e.adr  = 17'(((base / 4) * 4 + 4 * w) % 131072);
         e.data = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
         expQ.push_back(e);
      end
   endfunction

   // Monitor: every write strobe must match the next expected write, must not
   // follow another strobe, and must see in_ready low. done must see busy low.
   always @(negedge clk) begin
      if (!reset_n) begin
         prevWe = 1'b0;
      end else begin
         if (we) begin
            wr_t e;
            wr_t got;
            checkOutput("we_single_cycle", 32'(prevWe), 32'd0);
            checkOutput("in_ready_during_we", 32'(in_ready), 32'd0);
            got.adr  = adr;
            got.data = writedata;
            logQ.push_back(got);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_we_adr", 32'(adr), 32'h1ffff);
            end else begin
               e = expQ.pop_front();
               checkOutput("we_adr", 32'(adr), 32'(e.adr));
               checkOutput("we_data", writedata, e.data);
            end
         end
         if (done) begin
            doneCount++;
            checkOutput("busy_low_at_done", 32'(busy), 32'd0);
         end
         prevWe = we;
      end
   end

   task automatic startLoad(input int base, input int count);
      @(negedge clk);
      start      = 1'b1;
      base_adr   = 17'(base);
      word_count = 15'(count);
      startCyc   = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      bit accepted = 1'b0;
      repeat (gap) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         if (in_ready === 1'b1) begin
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
            accepted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("byte_accept_timeout", 32'(accepted), 32'd1);
   endtask

   task automatic waitDone(output int latency);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      latency = cyc - startCyc;
      checkOutput("done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic applyStimulus(input int base, input int count, input logic [7:0] bytes[$],
                                input int gap, output int latency);
      modelLoad(base, count, bytes);
      startLoad(base, count);
      checkOutput("in_ready_after_start", 32'(in_ready), 32'd1);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < bytes.size(); i++) sendByte(bytes[i], (i == 0) ? 0 : gap);
      waitDone(latency);
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_we"}, 32'(we), 32'd0);
      checkOutput({tag, "_adr"}, 32'(adr), 32'd0);
      checkOutput({tag, "_writedata"}, writedata, 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] bytes[$];
      int lat;
      int logBase;

      // Reset state
      repeat (3) @(negedge clk);
      checkZeroOutputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Three-word full-rate load from base 0
      bytes = '{8'h20, 8'h03, 8'h00, 8'h00, 8'h20, 8'h04, 8'h00, 8'h14,
                8'h20, 8'h05, 8'h00, 8'h00};
      logBase = logQ.size();
      applyStimulus(0, 3, bytes, 0, lat);
      checkOutput("three_word_latency", 32'(lat), 32'd16);
      checkOutput("three_word_count", 32'(logQ.size() - logBase), 32'd3);
      if (logQ.size() - logBase == 3) begin
         checkOutput("lit_w0_adr", 32'(logQ[logBase].adr), 32'h0);
         checkOutput("lit_w0_data", logQ[logBase].data, 32'h20030000);
         checkOutput("lit_w1_adr", 32'(logQ[logBase+1].adr), 32'h4);
         checkOutput("lit_w1_data", logQ[logBase+1].data, 32'h20040014);
         checkOutput("lit_w2_adr", 32'(logQ[logBase+2].adr), 32'h8);
         checkOutput("lit_w2_data", logQ[logBase+2].data, 32'h20050000);
      end
      checkOutput("three_word_adr_after", 32'(adr), 32'hC);

      // Unaligned base with three idle cycles between bytes
      bytes = '{8'ha0, 8'h03, 8'h00, 8'hff};
      logBase = logQ.size();
      applyStimulus(32'h1B, 1, bytes, 3, lat);
      checkOutput("stall_count", 32'(logQ.size() - logBase), 32'd1);
      if (logQ.size() > logBase) begin
         checkOutput("lit_stall_adr", 32'(logQ[logBase].adr), 32'h18);
         checkOutput("lit_stall_data", logQ[logBase].data, 32'ha00300ff);
      end
      checkOutput("stall_adr_after", 32'(adr), 32'h1C);

      // Address wrap at the top of the space
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      logBase = logQ.size();
      applyStimulus(32'h1FFFC, 2, bytes, 0, lat);
      checkOutput("wrap_latency", 32'(lat), 32'd11);
      if (logQ.size() - logBase == 2) begin
         checkOutput("lit_wrap0_adr", 32'(logQ[logBase].adr), 32'h1FFFC);
         checkOutput("lit_wrap1_adr", 32'(logQ[logBase+1].adr), 32'h0);
         checkOutput("lit_wrap1_data", logQ[logBase+1].data, 32'h55667788);
      end
      checkOutput("wrap_adr_after", 32'(adr), 32'h4);

      // Zero-count load: done in the cycle after start, no write
      logBase = logQ.size();
      startLoad(32'h40, 0);
      checkOutput("zero_done", 32'(done), 32'd1);
      checkOutput("zero_busy", 32'(busy), 32'd0);
      checkOutput("zero_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput("zero_done_pulse", 32'(done), 32'd0);
      checkOutput("zero_adr_kept", 32'(adr), 32'h4);
      checkOutput("zero_no_write", 32'(logQ.size() - logBase), 32'd0);

      // in_valid while idle is not consumed and raises nothing
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (3) begin
         @(negedge clk);
         checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      // start pulsed during COLLECT is ignored
      bytes = '{8'hca, 8'hfe, 8'hba, 8'hbe};
      logBase = logQ.size();
      modelLoad(32'h100, 1, bytes);
      startLoad(32'h100, 1);
      sendByte(8'hca, 0);
      sendByte(8'hfe, 0);
      start      = 1'b1;
      base_adr   = 17'h200;
      word_count = 15'd5;
      @(negedge clk);
      start = 1'b0;
      checkOutput("ignored_start_adr", 32'(adr), 32'h100);
      sendByte(8'hba, 0);
      sendByte(8'hbe, 0);
      waitDone(lat);
      checkOutput("ignored_start_count", 32'(logQ.size() - logBase), 32'd1);
      checkOutput("ignored_start_adr_after", 32'(adr), 32'h104);

      // Reset after two bytes of a word discards the partial word
      logBase = logQ.size();
      startLoad(32'h40, 2);
      sendByte(8'h01, 0);
      sendByte(8'h02, 0);
      reset_n = 1'b0;
      #1;
      checkZeroOutputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("midreset_no_write", 32'(logQ.size() - logBase), 32'd0);
      bytes = '{8'hde, 8'had, 8'hbe, 8'hef};
      applyStimulus(0, 1, bytes, 0, lat);
      checkOutput("after_reset_count", 32'(logQ.size() - logBase), 32'd1);
      if (logQ.size() > logBase) begin
         checkOutput("lit_after_reset_adr", 32'(logQ[logBase].adr), 32'h0);
         checkOutput("lit_after_reset_data", logQ[logBase].data, 32'hdeadbeef);
      end

      // Every modelled write was seen and every load completed once
      repeat (4) @(negedge clk);
      checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
      checkOutput("done_pulses", 32'(doneCount), 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instload.md
# instload

Boot-time program loader: the write side of the instruction memory. It accepts a byte stream over a valid/ready handshake and packs each four bytes into a big-endian 32-bit instruction word. Each word is written to the instruction RAM at consecutive word-aligned byte addresses from a programmed base. It sits between the host/UART receive path and the instruction memory's write port, ahead of the fetch unit's read path.

## Interface
- DATA_WIDTH, 32, instruction word width; fixed at 32 (four bytes per word).
- BUS_WIDTH, 17, byte-address width of the instruction memory.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_adr  in  BUS_WIDTH  first byte address; bits [1:0] forced to 0.
- word_count  in  BUS_WIDTH-2  number of words to load; sampled with start.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- we  out  1  instruction memory write enable, one cycle per word.
- adr  out  BUS_WIDTH  write byte address.
- writedata  out  DATA_WIDTH  write data.
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered.
- done  out  1  one-cycle pulse on completion.

## Operation
- Reset: all outputs 0; state IDLE; byte index, remaining count and assembly register cleared.
- IDLE: in_ready=0.
  - start=1 with word_count≠0: latch adr←{base_adr[BUS_WIDTH-1:2],2'b00}, remaining←word_count, byte index←0, go COLLECT.
  - start=1 with word_count=0: go DONE directly; no write occurs.
- COLLECT: in_ready=1. A byte is accepted when in_valid&in_ready.
  - Byte k (k=0..3) goes to bits [31-8k -: 8] (big-endian: first byte is the MSB).
  - When the 4th byte is accepted: writedata←assembled word, go WRITE.
- WRITE: in_ready=0, we=1 for exactly this cycle with adr/writedata stable.
  - Next cycle: adr←adr+4, wrapping modulo 2^BUS_WIDTH; remaining←remaining−1.
  - If remaining was 1, go DONE; else go COLLECT with byte index 0.
- DONE: done=1 for one cycle, busy=0, then IDLE. adr holds the last-written-plus-4 value until the next start.
- start outside IDLE is ignored, including during DONE.
- in_valid outside COLLECT is ignored; the byte is not consumed.
- Asynchronous reset mid-load discards the partial word; a word already written stays in memory.

## Timing
- in_ready is a registered state decode. No combinational path from in_valid to in_ready.
- 4th byte accepted at edge N → we=1 during cycle N+1 → COLLECT (in_ready=1) again from edge N+2.
- Minimum 5 cycles per word; a full-rate load of W words takes 5W cycles from first byte to last we, plus 1 cycle to the done pulse.
- start at edge S → in_ready=1 from cycle S+1 (nonzero count), or done=1 in cycle S+1 (zero count).
- Stalls: in_valid low holds the state, byte index and partial word indefinitely.
- we is never asserted for two consecutive cycles.

## Structure
- Package instload_pkg holds:
  - state enum {IDLE, COLLECT, WRITE, DONE};
  - BYTES_PER_WORD=4;
  - ADR_STEP=4.
- Sub-module instload_packer: 4-byte big-endian shift/assembly register with 2-bit byte index. Inputs: accept, clear, byte. Outputs: word, last (index==3 and accept).
- Top holds the FSM, address counter and remaining counter.

## Test plan
- Reset mid-op: assert reset_n=0 after 2 bytes of a word → all outputs 0, no we; new load at base 0x0 writes a correct first word.
- Three-word load: base 0x0, count 3, bytes 20 03 00 00 20 04 00 14 20 05 00 00 → we at 0x0=20030000, 0x4=20040014, 0x8=20050000; one done pulse; in_ready low in every WRITE cycle.
- Unaligned base with stall: base 0x1B, count 1, bytes a0 03 00 ff with in_valid deasserted 3 cycles between bytes → single write at 0x18 of a00300ff; partial word held across gaps.
- Wrap-around: base 0x1FFFC, count 2 → writes at 0x1FFFC then 0x00000.
- Zero count and ignored start: start with word_count=0 → done in the next cycle, no we; start pulsed during COLLECT → no change to adr/remaining.
